// File: rtl/peak_bin_detect.sv
// Scans FFT RAM 1 over [BIN_LO, BIN_HI], tracks the bin with maximum re^2+im^2
// and parks the read address there. Optional macro PEAK_THRESH_EN gates detectdone on MAG_THRESH.
module peak_bin_detect #(
    parameter int          BIN_LO     = 1,
    parameter int          BIN_HI     = 511,
    parameter int          RD_LAT     = 2,
    parameter logic [27:0] MAG_THRESH = 28'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fftdone,
    input  logic [27:0] ramq1,
    output logic [9:0]  rdaddr1,
    output logic [9:0]  maxbin,
    output logic [27:0] maxmag,
    output logic        busy,
    output logic        detectdone
);

    localparam logic [9:0] LO     = BIN_LO[9:0];
    localparam logic [9:0] HI     = BIN_HI[9:0];
    localparam logic [7:0] LAT_M1 = 8'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, SETTLE, DONE, HOLD} state_t;

    state_t                     r_state;
    logic [9:0]                 r_rdaddr;
    logic [9:0]                 r_maxbin;
    logic [27:0]                r_maxmag;
    logic                       r_busy;
    logic                       r_detectdone;
    logic                       r_first;
    logic [7:0]                 r_cnt;
    logic [RD_LAT-1:0]          r_vld_pipe;
    logic [RD_LAT-1:0][9:0]     r_bin_pipe;

    logic signed [27:0] w_re_sq;
    logic signed [27:0] w_im_sq;
    logic [27:0]        w_mag;
    logic [9:0]         w_tag_bin;
    logic               w_upd;
    logic [9:0]         w_next_maxbin;

    // Operands widen to 28 bits before squaring, so (-8192)^2 is exact.
    assign w_re_sq       = $signed(ramq1[27:14]) * $signed(ramq1[27:14]);
    assign w_im_sq       = $signed(ramq1[13:0]) * $signed(ramq1[13:0]);
    assign w_mag         = w_re_sq + w_im_sq;
    assign w_tag_bin     = r_bin_pipe[RD_LAT-1];
    // First word of a frame loads unconditionally; afterwards strict > keeps the lowest bin on ties.
    assign w_upd         = r_vld_pipe[RD_LAT-1] && (r_first || (w_mag > r_maxmag));
    assign w_next_maxbin = w_upd ? w_tag_bin : r_maxbin;

    assign rdaddr1    = r_rdaddr;
    assign maxbin     = r_maxbin;
    assign maxmag     = r_maxmag;
    assign busy       = r_busy;
    assign detectdone = r_detectdone;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rdaddr     <= '0;
            r_maxbin     <= '0;
            r_maxmag     <= '0;
            r_busy       <= 1'b0;
            r_detectdone <= 1'b0;
            r_first      <= 1'b0;
            r_cnt        <= '0;
            r_vld_pipe   <= '0;
            r_bin_pipe   <= '0;
        end else begin
            r_vld_pipe[0] <= (r_state == SCAN);
            r_bin_pipe[0] <= r_rdaddr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_bin_pipe[i] <= r_bin_pipe[i-1];
            end

            if (w_upd) begin
                r_maxmag <= w_mag;
                r_maxbin <= w_tag_bin;
                r_first  <= 1'b0;
            end

            case (r_state)
                IDLE, HOLD: begin
                    if (fftdone) begin
                        r_state  <= SCAN;
                        r_rdaddr <= LO;
                        r_busy   <= 1'b1;
                        r_first  <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                SCAN: begin
                    if (r_rdaddr == HI) begin
                        r_state <= DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_rdaddr <= r_rdaddr + 10'd1;
                    end
                end
                DRAIN: begin
                    if (r_cnt == LAT_M1) begin
                        r_state  <= SETTLE;
                        r_cnt    <= '0;
                        r_rdaddr <= w_next_maxbin;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (r_cnt == LAT_M1) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
`ifdef PEAK_THRESH_EN
                        r_detectdone <= (r_maxmag >= MAG_THRESH);
`else
                        r_detectdone <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_state      <= HOLD;
                    r_detectdone <= 1'b0;
`ifdef PEAK_THRESH_EN
                    if (r_maxmag < MAG_THRESH)
                        r_maxbin <= '0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peak_bin_detect.sv
// Self-checking bench for peak_bin_detect: table of frames, hand sequences for
// restart/reset corners, and random frames checked against a max-search model.
module tb_peak_bin_detect;

    localparam int LO       = 1;
    localparam int HI       = 511;
    localparam int LAT      = 2;
    localparam int N        = HI - LO + 1;
    localparam int DONE_LAT = N + 2 * LAT + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fftdone = 1'b0;
    logic [27:0] ramq1;
    logic [9:0]  rdaddr1, maxbin;
    logic [27:0] maxmag;
    logic        busy, detectdone;

    int tests = 0;
    int fails = 0;

    logic [27:0] ram [1024];
    logic [27:0] ram_d1;

    peak_bin_detect dut (
        .clk(clk), .reset(reset), .fftdone(fftdone), .ramq1(ramq1),
        .rdaddr1(rdaddr1), .maxbin(maxbin), .maxmag(maxmag),
        .busy(busy), .detectdone(detectdone)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency RAM model
    always @(posedge clk) begin
        ram_d1 <= ram[rdaddr1];
        ramq1  <= ram_d1;
    end

    typedef struct {
        int     b1; int re1; int im1;
        int     b2; int re2; int im2;
        int     bg_re; int bg_im;
        int     exp_bin;
        longint exp_mag;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [27:0] pack(input int re, input int im);
        logic [31:0] r, i;
        r = re; i = im;
        return {r[13:0], i[13:0]};
    endfunction

    function automatic longint power(input logic [27:0] w);
        longint re, im;
        re = longint'($signed(w[27:14]));
        im = longint'($signed(w[13:0]));
        return re * re + im * im;
    endfunction

    task automatic fill(input int re, input int im);
        for (int i = 0; i < 1024; i++) ram[i] = pack(re, im);
    endtask

    task automatic model(output int bin, output longint mag);
        longint p;
        mag = -1; bin = 0;
        for (int b = LO; b <= HI; b++) begin
            p = power(ram[b]);
            if (p > mag) begin mag = p; bin = b; end
        end
    endtask

    task automatic run_frame(input string nm, input int exp_bin, input longint exp_mag, input bit extra);
        int         n;
        int         dd_cnt;
        int         fall_at;
        bit         range_ok;
        bit         exp_dd;
        int         final_bin;
        logic [9:0] prev_bin;
`ifdef PEAK_THRESH_EN
        exp_dd = (exp_mag >= 4096);
`else
        exp_dd = 1'b1;
`endif
        final_bin = exp_dd ? exp_bin : 0;
        dd_cnt = 0; fall_at = -1; range_ok = 1'b1;
        @(negedge clk);
        prev_bin = maxbin;
        fftdone = 1'b1;
        @(negedge clk);
        fftdone = 1'b0;
        n = 1;
        chk({nm, " busy@S+1"}, busy, 1);
        chk({nm, " rdaddr@S+1"}, rdaddr1, LO);
        chk({nm, " maxbin kept@S+1"}, maxbin, prev_bin);
        while (n < DONE_LAT + 6) begin
            @(negedge clk);
            n++;
            fftdone = extra && (n == 50 || n == 300 || n == N + 2);
            if (rdaddr1 < LO || rdaddr1 > HI) range_ok = 1'b0;
            if (!busy && fall_at < 0) fall_at = n;
            if (detectdone) begin
                dd_cnt++;
                if (dd_cnt == 1) begin
                    chk({nm, " dd latency"}, n, DONE_LAT);
                    chk({nm, " maxbin"}, maxbin, exp_bin);
                    chk({nm, " maxmag"}, maxmag, exp_mag);
                    chk({nm, " ramq1@dd"}, ramq1, ram[exp_bin]);
                end
            end
        end
        fftdone = 1'b0;
        chk({nm, " dd count"}, dd_cnt, exp_dd ? 1 : 0);
        chk({nm, " busy fall"}, fall_at, DONE_LAT);
        chk({nm, " rdaddr range"}, range_ok, 1);
        chk({nm, " hold maxbin"}, maxbin, final_bin);
        chk({nm, " hold maxmag"}, maxmag, exp_mag);
        chk({nm, " hold rdaddr"}, rdaddr1, exp_bin);
    endtask

    vec_t vecs[8];

    initial begin
        int     rb;
        longint rm;
        bit     ok;

        vecs[0] = '{37, 1000, -500, -1, 0, 0, 10, 10, 37, 1250000};
        vecs[1] = '{100, 3000, 0, 200, 3000, 0, 0, 0, 100, 9000000};
        vecs[2] = '{511, -8192, -8192, -1, 0, 0, 0, 0, 511, 134217728};
        vecs[3] = '{0, 8000, 8000, -1, 0, 0, 0, 0, 1, 0};
        vecs[4] = '{1, -3, 4, 511, 4, 3, 0, 0, 1, 25};
        vecs[5] = '{512, 8191, 8191, 511, 2, 0, 1, 1, 511, 4};
        vecs[6] = '{77, 60, 20, -1, 0, 0, 0, 0, 77, 4000};
        vecs[7] = '{78, 70, 10, -1, 0, 0, 0, 0, 78, 5000};

        fill(0, 0);
        fftdone = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rdaddr1", rdaddr1, 0);
        chk("reset maxbin", maxbin, 0);
        chk("reset maxmag", maxmag, 0);
        chk("reset busy", busy, 0);
        chk("reset detectdone", detectdone, 0);
        reset = 1'b0; fftdone = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            fill(vecs[i].bg_re, vecs[i].bg_im);
            ram[vecs[i].b1] = pack(vecs[i].re1, vecs[i].im1);
            if (vecs[i].b2 >= 0) ram[vecs[i].b2] = pack(vecs[i].re2, vecs[i].im2);
            run_frame($sformatf("vec%0d", i), vecs[i].exp_bin, vecs[i].exp_mag, 1'b0);
        end

        // fftdone pulses during SCAN/DRAIN must be ignored
        fill(10, 10);
        ram[37] = pack(1000, -500);
        run_frame("extra_fftdone", 37, 1250000, 1'b1);

        // Restart from HOLD with a new peak
        fill(0, 0);
        ram[300] = pack(2000, 100);
        run_frame("hold_restart", 300, 4010000, 1'b0);

        // Reset mid-scan, coincident with fftdone
        fill(5, 5);
        ram[123] = pack(-400, 300);
        @(negedge clk);
        fftdone = 1'b1;
        @(negedge clk);
        fftdone = 1'b0;
        repeat (199) @(negedge clk);
        reset = 1'b1; fftdone = 1'b1;
        @(negedge clk);
        reset = 1'b0; fftdone = 1'b0;
        chk("midrst rdaddr1", rdaddr1, 0);
        chk("midrst maxbin", maxbin, 0);
        chk("midrst maxmag", maxmag, 0);
        chk("midrst busy", busy, 0);
        ok = 1'b1;
        repeat (600) begin
            @(negedge clk);
            if (detectdone || busy || rdaddr1 != 0) ok = 1'b0;
        end
        chk("midrst stays idle", ok, 1);
        run_frame("after_reset", 123, 250000, 1'b0);

        // Random full-scale frames and low-amplitude frames (many ties)
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 1024; i++) begin
                if (f < 2) ram[i] = 28'($urandom);
                else       ram[i] = pack(int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
            end
            model(rb, rm);
            run_frame($sformatf("rand%0d", f), rb, rm, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/peak_bin_detect.md
Name: peak_bin_detect

Overview:
- Frequency-detect stage directly upstream of the beamforming weight block.
- After the FFT of channel 1 lands in FFT RAM 1, scans a bin range, computes |X|² per bin, and finds the bin with maximum power.
- Publishes that bin as maxbin, parks the RAM 1 read address on it, and pulses detectdone so the weight block can latch all four channels at that bin.

Parameters:
- BIN_LO, 1, first bin scanned (skips DC).
- BIN_HI, 511, last bin scanned, inclusive; BIN_LO ≤ BIN_HI ≤ 1023 required.
- RD_LAT, 2, FFT RAM read latency in cycles (address to valid ramq1).
- MAG_THRESH, 28'd4096, minimum peak power; used only with PEAK_THRESH_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fftdone  in  1  one-cycle pulse: FFT RAM 1 holds a new frame
- ramq1  in  28  FFT RAM 1 read data; [27:14] signed real, [13:0] signed imag
- rdaddr1  out  10  FFT RAM 1 read address
- maxbin  out  10  bin of peak power
- maxmag  out  28  peak power, re²+im², unsigned
- busy  out  1  high from the cycle after start acceptance until detectdone
- detectdone  out  1  one-cycle pulse: maxbin valid; ramq1 already shows the maxbin data

Behaviour:
- Reset values:
  - rdaddr1 = 0, maxbin = 0, maxmag = 0, busy = 0, detectdone = 0.
  - State = IDLE; all counters cleared.
- Reset mid-scan aborts the frame. The next frame starts only on a new fftdone.
- States: IDLE, SCAN, DRAIN, SETTLE, DONE, HOLD.
- Start: fftdone is sampled in IDLE or HOLD (cycle S).
  - Clears the running max and bin counters.
  - Next state is SCAN; busy = 1 from S+1.
  - fftdone in any other state is ignored; it is neither queued nor allowed to restart the scan.
- SCAN (N = BIN_HI-BIN_LO+1 cycles, S+1..S+N):
  - rdaddr1 = BIN_LO+k at the k-th SCAN cycle, one address per cycle.
  - A delay line of depth RD_LAT tags returning data with its bin and a valid bit.
- DRAIN (RD_LAT cycles): rdaddr1 is held at BIN_HI while the last data returns.
- Compare: in every cycle a tagged word arrives, compute mag = re² + im².
  - re and im are sign-extended; each square is 27 bits; the sum fits in 28 bits with no overflow.
  - (-8192)² + (-8192)² = 2^27 must be exact.
  - If mag > maxmag (strict), update maxmag and maxbin on that edge.
  - Ties keep the lowest bin.
  - An all-zero frame yields maxbin = BIN_LO, maxmag = 0.
- SETTLE (RD_LAT cycles): rdaddr1 = maxbin.
- DONE (1 cycle): detectdone = 1, busy = 0 in the same cycle; ramq1 presents the data at maxbin.
  - detectdone is at cycle S + N + 2·RD_LAT + 1 (defaults: S+516).
- HOLD:
  - rdaddr1, maxbin, and maxmag stay frozen until reset or the next fftdone.
  - detectdone stays 0, so the downstream block never re-triggers on a stale frame.
- A new fftdone in HOLD starts a new scan immediately. maxbin/maxmag keep the old values until the first compare of the new frame.
- fftdone coincident with reset: reset wins.
- rdaddr1 never leaves [BIN_LO, BIN_HI] except the reset value 0.

Optional Feature:
- Macro PEAK_THRESH_EN.
- When defined:
  - In DONE, if maxmag < MAG_THRESH, suppress detectdone (stays 0).
  - Go to HOLD with maxbin forced to 0 and maxmag kept.
  - busy still drops; downstream is not triggered on noise-only frames.
- When undefined: detectdone always pulses in DONE regardless of magnitude, and MAG_THRESH is unused.

Test Plan:
- Single tone: RAM model (latency 2) holds bin 37 = (1000, -500), all other bins = (10, 10); pulse fftdone -> detectdone exactly 516 cycles later, maxbin = 37, maxmag = 1250000, ramq1 = bin-37 data during the detectdone cycle.
- Tie: bins 100 and 200 both (3000, 0), rest 0 -> maxbin = 100, maxmag = 9000000.
- Extremes and boundaries:
  - Bin 511 = (-8192, -8192) -> maxbin = 511, maxmag = 134217728.
  - Only bin 0 (outside range) huge, rest 0 -> maxbin = 1, maxmag = 0.
- Back-to-back and busy: extra fftdone pulses during SCAN -> ignored, single detectdone. fftdone in HOLD with a new peak at bin 300 -> second detectdone, maxbin = 300.
- Reset at cycle S+200 -> all outputs 0, state IDLE, no detectdone; the following fftdone completes normally.
- PEAK_THRESH_EN build:
  - Peak power 4000 -> no detectdone, maxbin = 0, busy falls at S+516.
  - Peak power 5000 -> detectdone pulses.
